// File: rtl/tx_conn.sv
// tx_conn: ASCII frame transmitter for the AGC host link (outbound side of rx_conn).
// Snapshots PROG/VERB/NOUN and R1..R3, then emits a 26-byte frame over valid/ready.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   send_req              start one frame (only looked at while idle)
//   data_PROG/VERB/NOUN   two octal digits each, digit k in [k]
//   data_R1/R2/R3         15-bit ones' complement words, bit 14 = sign
//   TX_byte, TX_valid     byte offered to the UART, held until accepted
//   TX_ready              UART takes the byte this cycle
//   busy                  frame or post-frame gap in progress
//   frame_done            one-cycle pulse after END_CHAR is accepted
module tx_conn #(
  parameter logic [7:0] START_CHAR = 8'd60,
  parameter logic [7:0] END_CHAR   = 8'd62,
  parameter int         GAP_CYCLES = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            send_req,
  input  logic [1:0][2:0] data_PROG,
  input  logic [1:0][2:0] data_VERB,
  input  logic [1:0][2:0] data_NOUN,
  input  logic [14:0]     data_R1,
  input  logic [14:0]     data_R2,
  input  logic [14:0]     data_R3,
  output logic [7:0]      TX_byte,
  output logic            TX_valid,
  input  logic            TX_ready,
  output logic            busy,
  output logic            frame_done
);

  typedef enum logic [2:0] {
    IDLE, START, UNSIGNED, SIGNED, ENDF, GAP
  } state_t;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t          state, state_n;
  logic [2:0]      digit, digit_n;
  logic [1:0]      field, field_n;
  logic [GW-1:0]   gap_cnt, gap_cnt_n;
  logic            done_n;
  logic            load;

  logic [1:0][2:0] prog_q, verb_q, noun_q;
  logic [14:0]     r1_q, r2_q, r3_q;

  logic [1:0][2:0] pair;
  logic [14:0]     word;
  logic [14:0]     mag;
  logic [14:0]     sh;

  always_comb begin
    pair = noun_q;
    word = r3_q;
    unique case (field)
      2'd0:    begin pair = prog_q; word = r1_q; end
      2'd1:    begin pair = verb_q; word = r2_q; end
      default: begin pair = noun_q; word = r3_q; end
    endcase
    // ones' complement magnitude; -0 stays as all-zero digits
    mag = word[14] ? ~word : word;
    // shift by 3*digit to bring the wanted octal digit to bit 0
    sh  = mag >> ({2'b00, digit} + {1'b0, digit, 1'b0});
  end

  always_comb begin
    state_n   = state;
    digit_n   = digit;
    field_n   = field;
    gap_cnt_n = gap_cnt;
    done_n    = 1'b0;
    load      = 1'b0;
    TX_valid  = 1'b0;
    TX_byte   = 8'd0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (send_req) begin
          load    = 1'b1;
          state_n = START;
        end
      end
      START: begin
        TX_valid = 1'b1;
        TX_byte  = START_CHAR;
        if (TX_ready) begin
          state_n = UNSIGNED;
          field_n = 2'd0;
          digit_n = 3'd0;
        end
      end
      UNSIGNED: begin
        TX_valid = 1'b1;
        TX_byte  = 8'd48 + {5'd0, pair[digit[0]]};
        if (TX_ready) begin
          if (digit == 3'd1) begin
            digit_n = 3'd0;
            if (field == 2'd2) begin
              state_n = SIGNED;
              field_n = 2'd0;
            end else begin
              field_n = field + 2'd1;
            end
          end else begin
            digit_n = digit + 3'd1;
          end
        end
      end
      SIGNED: begin
        TX_valid = 1'b1;
        if (digit == 3'd5) TX_byte = word[14] ? 8'd45 : 8'd43;
        else               TX_byte = 8'd48 + {5'd0, sh[2:0]};
        if (TX_ready) begin
          if (digit == 3'd5) begin
            digit_n = 3'd0;
            if (field == 2'd2) state_n = ENDF;
            else               field_n = field + 2'd1;
          end else begin
            digit_n = digit + 3'd1;
          end
        end
      end
      ENDF: begin
        TX_valid = 1'b1;
        TX_byte  = END_CHAR;
        if (TX_ready) begin
          done_n    = 1'b1;
          gap_cnt_n = '0;
          state_n   = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_n = IDLE;
        else gap_cnt_n = gap_cnt + GW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      digit      <= 3'd0;
      field      <= 2'd0;
      gap_cnt    <= '0;
      frame_done <= 1'b0;
      prog_q     <= '0;
      verb_q     <= '0;
      noun_q     <= '0;
      r1_q       <= '0;
      r2_q       <= '0;
      r3_q       <= '0;
    end else begin
      state      <= state_n;
      digit      <= digit_n;
      field      <= field_n;
      gap_cnt    <= gap_cnt_n;
      frame_done <= done_n;
      if (load) begin
        prog_q <= data_PROG;
        verb_q <= data_VERB;
        noun_q <= data_NOUN;
        r1_q   <= data_R1;
        r2_q   <= data_R2;
        r3_q   <= data_R3;
      end
    end
  end

endmodule

// File: tb/tb_tx_conn.sv
// tb_tx_conn: directed bench for tx_conn with a byte scoreboard
// and a bench-side frame decoder standing in for rx_conn.
module tb_tx_conn;

  logic            clk = 1'b0;
  logic            reset;
  logic            send_req, send_req_g;
  logic [1:0][2:0] prog, verb, noun;
  logic [14:0]     r1, r2, r3;
  logic            TX_ready;
  logic [7:0]      TX_byte, TX_byte_g;
  logic            TX_valid, TX_valid_g;
  logic            busy, busy_g;
  logic            frame_done, frame_done_g;

  always #5 clk = ~clk;

  tx_conn dut (
    .clk(clk), .reset(reset), .send_req(send_req),
    .data_PROG(prog), .data_VERB(verb), .data_NOUN(noun),
    .data_R1(r1), .data_R2(r2), .data_R3(r3),
    .TX_byte(TX_byte), .TX_valid(TX_valid), .TX_ready(TX_ready),
    .busy(busy), .frame_done(frame_done)
  );

  tx_conn #(.GAP_CYCLES(4)) dut_g (
    .clk(clk), .reset(reset), .send_req(send_req_g),
    .data_PROG(prog), .data_VERB(verb), .data_NOUN(noun),
    .data_R1(r1), .data_R2(r2), .data_R3(r3),
    .TX_byte(TX_byte_g), .TX_valid(TX_valid_g), .TX_ready(TX_ready),
    .busy(busy_g), .frame_done(frame_done_g)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_q[$];

  task automatic push_reg(input logic [14:0] w);
    logic [14:0] m;
    m = w[14] ? ~w : w;
    for (int k = 0; k < 5; k++) exp_q.push_back(8'd48 + {5'd0, m[3*k +: 3]});
    exp_q.push_back(w[14] ? 8'd45 : 8'd43);
  endtask

  task automatic push_frame();
    exp_q.push_back(8'd60);
    for (int k = 0; k < 2; k++) exp_q.push_back(8'd48 + {5'd0, prog[k]});
    for (int k = 0; k < 2; k++) exp_q.push_back(8'd48 + {5'd0, verb[k]});
    for (int k = 0; k < 2; k++) exp_q.push_back(8'd48 + {5'd0, noun[k]});
    push_reg(r1);
    push_reg(r2);
    push_reg(r3);
    exp_q.push_back(8'd62);
  endtask

  int          cyc = 0;
  int          fd_cnt = 0;
  int          first_cyc = 0, last_cyc = 0;
  int          nbuf = 0;
  logic [7:0]  rxbuf [26];
  logic [7:0]  exp_b;
  logic [5:0]  dec_verb, dec_noun;
  logic [14:0] dec_r [3];
  logic [14:0] dm;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (TX_valid && TX_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", {24'd0, TX_byte}, 32'hffff);
      end else begin
        exp_b = exp_q.pop_front();
        chk("byte", {24'd0, TX_byte}, {24'd0, exp_b});
      end
      if (TX_byte == 8'd60) begin
        first_cyc = cyc;
        nbuf = 0;
      end
      if (nbuf < 26) rxbuf[nbuf] = TX_byte;
      nbuf++;
      if (TX_byte == 8'd62 && nbuf == 26) begin
        last_cyc = cyc;
        dec_verb = {rxbuf[4][2:0], rxbuf[3][2:0]};
        dec_noun = {rxbuf[6][2:0], rxbuf[5][2:0]};
        for (int j = 0; j < 3; j++) begin
          dm = '0;
          for (int k = 0; k < 5; k++) dm[3*k +: 3] = rxbuf[7+6*j+k][2:0];
          dec_r[j] = (rxbuf[12+6*j] == 8'd45) ? ~dm : dm;
        end
      end
    end
  end

  task automatic pulse_req();
    @(posedge clk); #1 send_req = 1'b1;
    @(posedge clk); #1 send_req = 1'b0;
  endtask

  task automatic wait_xfers(input int n);
    int c = 0;
    for (int i = 0; i < 500 && c < n; i++) begin
      @(negedge clk);
      if (TX_valid && TX_ready) c++;
    end
    if (c < n) chk("wait_xfers_timeout", c, n);
  endtask

  task automatic wait_done();
    int ok = 0;
    for (int i = 0; i < 500 && ok == 0; i++) begin
      @(negedge clk);
      if (frame_done) ok = 1;
    end
    chk("frame_done_seen", ok, 1);
    chk("busy_at_done", {31'd0, busy}, 0);
  endtask

  task automatic set_base();
    prog = {3'd3, 3'd7};
    verb = {3'd1, 3'd6};
    noun = {3'd0, 3'd1};
    r1   = 15'o00123;
    r2   = 15'o77654;
    r3   = 15'o77777;
  endtask

  int fd0;
  int vcnt;
  int found;

  initial begin
    reset      = 1'b1;
    send_req   = 1'b0;
    send_req_g = 1'b0;
    TX_ready   = 1'b1;
    set_base();

    // reset state and quiet idle
    @(posedge clk); @(negedge clk);
    chk("reset_state", {22'd0, TX_valid, busy, frame_done, TX_byte}, 0);
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_quiet", {22'd0, TX_valid, busy, frame_done, TX_byte}, 0);
    end

    // full-rate frame and round-trip decode
    push_frame();
    fd0 = fd_cnt;
    pulse_req();
    wait_done();
    @(negedge clk);
    chk("fd_once_t2", fd_cnt - fd0, 1);
    chk("span_26", last_cyc - first_cyc, 25);
    chk("queue_empty_t2", exp_q.size(), 0);
    chk("dec_verb", {26'd0, dec_verb}, {26'd0, verb});
    chk("dec_noun", {26'd0, dec_noun}, {26'd0, noun});
    chk("dec_r1", {17'd0, dec_r[0]}, {17'd0, r1});
    chk("dec_r2", {17'd0, dec_r[1]}, {17'd0, r2});
    chk("dec_r3", {17'd0, dec_r[2]}, {17'd0, r3});

    // backpressure after the 4th byte
    push_frame();
    fd0 = fd_cnt;
    pulse_req();
    wait_xfers(4);
    @(posedge clk); #1 TX_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, TX_valid}, 1);
      chk("stall_byte", {24'd0, TX_byte}, 32'h31);
    end
    @(posedge clk); #1 TX_ready = 1'b1;
    wait_done();
    @(negedge clk);
    chk("fd_once_t3", fd_cnt - fd0, 1);
    chk("queue_empty_t3", exp_q.size(), 0);

    // request while busy is ignored; snapshot held
    push_frame();
    fd0 = fd_cnt;
    pulse_req();
    wait_xfers(12);
    @(posedge clk); #1;
    verb     = {3'd5, 3'd2};
    r1       = 15'o12345;
    r3       = 15'o00007;
    send_req = 1'b1;
    @(posedge clk); #1 send_req = 1'b0;
    wait_done();
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (TX_valid) vcnt++;
    end
    chk("fd_once_t4", fd_cnt - fd0, 1);
    chk("no_queued_frame", vcnt, 0);
    chk("queue_empty_t4", exp_q.size(), 0);
    set_base();

    // reset mid-frame aborts it
    push_frame();
    pulse_req();
    wait_xfers(15);
    @(posedge clk); #1;
    TX_ready = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
    TX_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("abort_valid", {31'd0, TX_valid}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", {31'd0, TX_valid}, 0);
    push_frame();
    fd0 = fd_cnt;
    pulse_req();
    wait_done();
    @(negedge clk);
    chk("fd_once_t5", fd_cnt - fd0, 1);
    chk("queue_empty_t5", exp_q.size(), 0);

    // GAP_CYCLES=4 with request held high
    @(posedge clk); #1 send_req_g = 1'b1;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (TX_valid_g && TX_byte_g == 8'd62) found = 1;
    end
    chk("gap_end_seen", found, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("gap_valid_low", {31'd0, TX_valid_g}, 0);
      chk("gap_busy", {31'd0, busy_g}, (i < 4) ? 1 : 0);
      if (i == 0) chk("gap_done_pulse", {31'd0, frame_done_g}, 1);
    end
    @(negedge clk);
    chk("gap_next_start", {23'd0, TX_valid_g, TX_byte_g}, {23'd1, 8'd60});
    @(posedge clk); #1 send_req_g = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
